// File: rtl/gshare_predictor_state.sv
// gshare_predictor_state: saturating-counter predictor RAM with init sweep.
// Optional gshare indexing when PS_GSHARE_EN is defined; bimodal otherwise.
module gshare_predictor_state #(
   parameter int PS_SIZE   = 8,
   parameter int CTR_WIDTH = 2,
   parameter int GHR_SIZE  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PS_SIZE-1:0]   fch_addr_nxt,
   input  logic                 fch_predict,
   output logic [CTR_WIDTH-1:0] fch_pred_state,
   output logic                 fch_pred_taken,
   output logic [PS_SIZE-1:0]   fch_ps_addr,
   output logic                 ps_ready,
   input  logic                 wrb_update_bpu,
   input  logic                 wrb_was_pred,
   input  logic [CTR_WIDTH-1:0] wrb_ps_state,
   input  logic [PS_SIZE-1:0]   wrb_ps_addr,
   input  logic                 wrb_direction
);

   localparam int DEPTH = 1 << PS_SIZE;

   localparam logic [CTR_WIDTH-1:0] WEAK_NT =
      CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
   localparam logic [CTR_WIDTH-1:0] WEAK_T =
      CTR_WIDTH'(1 << (CTR_WIDTH - 1));
   localparam logic [CTR_WIDTH-1:0] MAX =
      CTR_WIDTH'((1 << CTR_WIDTH) - 1);
   localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);
   localparam logic [CTR_WIDTH-1:0] CTR_ZERO = '0;
   localparam logic [PS_SIZE-1:0]   IDX_ONE  = PS_SIZE'(1);
   localparam logic [PS_SIZE-1:0]   IDX_LAST = PS_SIZE'(DEPTH - 1);

   // Reject parameter combinations the counter/history logic cannot honour
   generate
      if (CTR_WIDTH < 2 || CTR_WIDTH > 4) begin : g_bad_ctr
         $error("CTR_WIDTH must be within 2..4");
      end
      if (GHR_SIZE < 1 || GHR_SIZE > PS_SIZE) begin : g_bad_ghr
         $error("GHR_SIZE must be within 1..PS_SIZE");
      end
   endgenerate

   typedef enum logic {
      S_INIT,
      S_READY
   } state_e;

   state_e                 state_q, state_d;
   logic [PS_SIZE-1:0]     sweep_idx_q, sweep_idx_d;
   logic [CTR_WIDTH-1:0]   fch_pred_state_q, fch_pred_state_d;
   logic [PS_SIZE-1:0]     fch_ps_addr_q, fch_ps_addr_d;
   logic                   ps_ready_q, ps_ready_d;

   logic [CTR_WIDTH-1:0]   ram_q [DEPTH];

   logic                   active;
   logic                   upd_en;
   logic                   rd_en;
   logic [CTR_WIDTH-1:0]   upd_data;
   logic [PS_SIZE-1:0]     idx;
   logic [CTR_WIDTH-1:0]   rd_data;
   logic                   wr_en;
   logic [PS_SIZE-1:0]     wr_addr;
   logic [CTR_WIDTH-1:0]   wr_data;

   assign active = (state_q == S_READY);
   assign upd_en = active & wrb_update_bpu;
   assign rd_en  = active & fch_predict;

`ifdef PS_GSHARE_EN
   logic [GHR_SIZE-1:0] ghr_q, ghr_d;

   // Shift resolved outcomes into history; frozen until sweep completes
   always_comb begin
      ghr_d = ghr_q;
      if (upd_en) begin
         ghr_d = GHR_SIZE'({ghr_q, wrb_direction});
      end
   end

   // History register, cleared on reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   // gshare index uses pre-update history
   assign idx = fch_addr_nxt ^ PS_SIZE'(ghr_q);
`else
   // Bimodal index: fetch address used directly
   assign idx = fch_addr_nxt;
`endif

   // New counter value from the resolved branch outcome
   always_comb begin
      upd_data = WEAK_NT;
      if (wrb_was_pred) begin
         if (wrb_direction) begin
            if (wrb_ps_state == MAX) begin
               upd_data = MAX;
            end else begin
               upd_data = wrb_ps_state + CTR_ONE;
            end
         end else begin
            if (wrb_ps_state == CTR_ZERO) begin
               upd_data = CTR_ZERO;
            end else begin
               upd_data = wrb_ps_state - CTR_ONE;
            end
         end
      end else begin
         if (wrb_direction) begin
            upd_data = WEAK_T;
         end else begin
            upd_data = WEAK_NT;
         end
      end
   end

   // Single write port shared by the init sweep and branch updates
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = wrb_ps_addr;
      wr_data = upd_data;
      if (state_q == S_INIT) begin
         wr_en   = reset;
         wr_addr = sweep_idx_q;
         wr_data = WEAK_NT;
      end else begin
         wr_en   = reset & wrb_update_bpu;
         wr_addr = wrb_ps_addr;
         wr_data = upd_data;
      end
   end

   // Counter storage; no reset so it can map onto block RAM
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ram_q[wr_addr] <= wr_data;
      end
   end

   // Read data with forwarding of a same-cycle update to the same entry
   always_comb begin
      rd_data = ram_q[idx];
      if (upd_en && (wrb_ps_addr == idx)) begin
         rd_data = upd_data;
      end
   end

   // Sweep FSM next state and registered lookup results
   always_comb begin
      state_d          = state_q;
      sweep_idx_d      = sweep_idx_q;
      fch_pred_state_d = fch_pred_state_q;
      fch_ps_addr_d    = fch_ps_addr_q;
      unique case (state_q)
         S_INIT: begin
            sweep_idx_d = sweep_idx_q + IDX_ONE;
            if (sweep_idx_q == IDX_LAST) begin
               state_d = S_READY;
            end
         end
         S_READY: begin
            if (rd_en) begin
               fch_pred_state_d = rd_data;
               fch_ps_addr_d    = idx;
            end
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
      ps_ready_d = (state_d == S_READY);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q          <= S_INIT;
         sweep_idx_q      <= '0;
         fch_pred_state_q <= WEAK_NT;
         fch_ps_addr_q    <= '0;
         ps_ready_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         sweep_idx_q      <= sweep_idx_d;
         fch_pred_state_q <= fch_pred_state_d;
         fch_ps_addr_q    <= fch_ps_addr_d;
         ps_ready_q       <= ps_ready_d;
      end
   end

   assign fch_pred_state = fch_pred_state_q;
   assign fch_pred_taken = fch_pred_state_q[CTR_WIDTH-1];
   assign fch_ps_addr    = fch_ps_addr_q;
   assign ps_ready       = ps_ready_q;

endmodule

// File: tb/tb_gshare_predictor_state.sv
// tb_gshare_predictor_state: directed checks of the predictor state RAM.
// Two instances: CTR_WIDTH=2 and CTR_WIDTH=3, PS_SIZE=4, GHR_SIZE=4.
module tb_gshare_predictor_state;

   logic       clk;
   logic       reset;
   logic [3:0] fch_addr_nxt;
   logic       fch_predict;
   logic       wrb_update_bpu;
   logic       wrb_was_pred;
   logic [1:0] wrb_ps_state;
   logic [2:0] wrb_ps_state3;
   logic [3:0] wrb_ps_addr;
   logic       wrb_direction;

   logic [1:0] fch_pred_state;
   logic       fch_pred_taken;
   logic [3:0] fch_ps_addr;
   logic       ps_ready;
   logic [2:0] fch_pred_state3;
   logic       fch_pred_taken3;
   logic [3:0] fch_ps_addr3;
   logic       ps_ready3;

   int checks = 0;
   int errors = 0;
   logic [3:0] ghr_m;

   gshare_predictor_state #(
      .PS_SIZE(4), .CTR_WIDTH(2), .GHR_SIZE(4)
   ) dut (
      .clk(clk), .reset(reset),
      .fch_addr_nxt(fch_addr_nxt), .fch_predict(fch_predict),
      .fch_pred_state(fch_pred_state), .fch_pred_taken(fch_pred_taken),
      .fch_ps_addr(fch_ps_addr), .ps_ready(ps_ready),
      .wrb_update_bpu(wrb_update_bpu), .wrb_was_pred(wrb_was_pred),
      .wrb_ps_state(wrb_ps_state), .wrb_ps_addr(wrb_ps_addr),
      .wrb_direction(wrb_direction)
   );

   gshare_predictor_state #(
      .PS_SIZE(4), .CTR_WIDTH(3), .GHR_SIZE(4)
   ) dut3 (
      .clk(clk), .reset(reset),
      .fch_addr_nxt(fch_addr_nxt), .fch_predict(fch_predict),
      .fch_pred_state(fch_pred_state3), .fch_pred_taken(fch_pred_taken3),
      .fch_ps_addr(fch_ps_addr3), .ps_ready(ps_ready3),
      .wrb_update_bpu(wrb_update_bpu), .wrb_was_pred(wrb_was_pred),
      .wrb_ps_state(wrb_ps_state3), .wrb_ps_addr(wrb_ps_addr),
      .wrb_direction(wrb_direction)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       upd;
      logic       wp;
      logic [1:0] st;
      logic [3:0] waddr;
      logic       dir;
      logic       pred;
      logic [3:0] laddr;
      logic [1:0] e_state;
      logic       e_taken;
      logic [3:0] e_addr;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      fch_addr_nxt   = '0;
      fch_predict    = 1'b0;
      wrb_update_bpu = 1'b0;
      wrb_was_pred   = 1'b0;
      wrb_ps_state   = '0;
      wrb_ps_state3  = '0;
      wrb_ps_addr    = '0;
      wrb_direction  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle();
      tick();
      reset = 1'b1;
      ghr_m = '0;
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 64 && !(ps_ready && ps_ready3); k++) tick();
      chk("ready_wait", {30'd0, ps_ready, ps_ready3}, 32'd3);
   endtask

   function automatic logic [3:0] ghr_eff();
`ifdef PS_GSHARE_EN
      return ghr_m;
`else
      return 4'h0;
`endif
   endfunction

   task automatic lookup_all_weak(input string name);
      for (int i = 0; i < 16; i++) begin
         fch_predict  = 1'b1;
         fch_addr_nxt = 4'(i) ^ ghr_eff();
         tick();
         chk({name, "_state"}, 32'(fch_pred_state), 32'h1);
         chk({name, "_addr"}, 32'(fch_ps_addr), 32'(i));
         chk({name, "_state3"}, 32'(fch_pred_state3), 32'h3);
      end
      idle();
   endtask

   initial begin
      reset = 1'b1;
      ghr_m = '0;
      idle();

      vecs[0]  = '{1, 1, 2'd3, 4'd5,  1, 1, 4'd0,  2'd1, 0, 4'd0};
      vecs[1]  = '{0, 0, 2'd0, 4'd0,  0, 1, 4'd5,  2'd3, 1, 4'd5};
      vecs[2]  = '{1, 1, 2'd0, 4'd5,  0, 1, 4'd1,  2'd1, 0, 4'd1};
      vecs[3]  = '{0, 0, 2'd0, 4'd0,  0, 1, 4'd5,  2'd0, 0, 4'd5};
      vecs[4]  = '{1, 0, 2'd0, 4'd3,  1, 1, 4'd2,  2'd1, 0, 4'd2};
      vecs[5]  = '{0, 0, 2'd0, 4'd0,  0, 1, 4'd3,  2'd2, 1, 4'd3};
      vecs[6]  = '{1, 1, 2'd2, 4'd7,  1, 1, 4'd7,  2'd3, 1, 4'd7};
      vecs[7]  = '{1, 1, 2'd1, 4'd7,  1, 1, 4'd3,  2'd2, 1, 4'd3};
      vecs[8]  = '{0, 0, 2'd0, 4'd0,  0, 1, 4'd7,  2'd2, 1, 4'd7};
      vecs[9]  = '{1, 0, 2'd0, 4'd9,  0, 1, 4'd9,  2'd1, 0, 4'd9};
      vecs[10] = '{1, 1, 2'd2, 4'd9,  0, 1, 4'd5,  2'd0, 0, 4'd5};
      vecs[11] = '{1, 1, 2'd0, 4'd5,  1, 0, 4'd0,  2'd0, 0, 4'd5};
      vecs[12] = '{0, 0, 2'd0, 4'd0,  0, 1, 4'd5,  2'd1, 0, 4'd5};
      vecs[13] = '{1, 1, 2'd1, 4'd12, 0, 1, 4'd12, 2'd0, 0, 4'd12};

      // Reset values and init sweep timing, with traffic that must be ignored
      do_reset();
      chk("rst_state", 32'(fch_pred_state), 32'h1);
      chk("rst_taken", 32'(fch_pred_taken), 32'h0);
      chk("rst_addr", 32'(fch_ps_addr), 32'h0);
      chk("rst_ready", 32'(ps_ready), 32'h0);
      for (int e = 1; e <= 16; e++) begin
         fch_predict    = 1'b1;
         fch_addr_nxt   = 4'(e + 3);
         wrb_update_bpu = 1'b1;
         wrb_was_pred   = 1'b0;
         wrb_direction  = 1'b1;
         wrb_ps_addr    = 4'(e - 1);
         tick();
         chk("init_ready", 32'(ps_ready), (e >= 16) ? 32'h1 : 32'h0);
         chk("init_addr", 32'(fch_ps_addr), 32'h0);
      end
      idle();
      lookup_all_weak("init_lookup");

      // Table-driven update/lookup vectors
      for (int i = 0; i < 14; i++) begin
         wrb_update_bpu = vecs[i].upd;
         wrb_was_pred   = vecs[i].wp;
         wrb_ps_state   = vecs[i].st;
         wrb_ps_state3  = {1'b0, vecs[i].st};
         wrb_ps_addr    = vecs[i].waddr;
         wrb_direction  = vecs[i].dir;
         fch_predict    = vecs[i].pred;
         fch_addr_nxt   = vecs[i].laddr ^ ghr_eff();
         tick();
         if (vecs[i].upd) ghr_m = {ghr_m[2:0], vecs[i].dir};
         chk($sformatf("vec%0d_state", i), 32'(fch_pred_state),
             32'(vecs[i].e_state));
         chk($sformatf("vec%0d_taken", i), 32'(fch_pred_taken),
             32'(vecs[i].e_taken));
         chk($sformatf("vec%0d_addr", i), 32'(fch_ps_addr),
             32'(vecs[i].e_addr));
         if (i == 5) begin
            chk("w3_first_state", 32'(fch_pred_state3), 32'h4);
            chk("w3_first_taken", 32'(fch_pred_taken3), 32'h1);
            chk("w3_first_addr", 32'(fch_ps_addr3), 32'h3);
         end
      end
      idle();

      // History hash: outcomes 1,0,1,1 then lookup 0x0F
      do_reset();
      wait_ready();
      for (int k = 0; k < 4; k++) begin
         wrb_update_bpu = 1'b1;
         wrb_was_pred   = 1'b0;
         wrb_ps_addr    = 4'h0;
         wrb_direction  = (k != 1);
         tick();
      end
      idle();
      fch_predict  = 1'b1;
      fch_addr_nxt = 4'hF;
      tick();
`ifdef PS_GSHARE_EN
      chk("gshare_addr", 32'(fch_ps_addr), 32'h4);
`else
      chk("gshare_addr", 32'(fch_ps_addr), 32'hF);
`endif
      idle();

      // Reset in the middle of the sweep restarts it from index 0
      do_reset();
      for (int e = 1; e <= 9; e++) tick();
      chk("mid_ready_pre", 32'(ps_ready), 32'h0);
      do_reset();
      chk("mid_ready_rst", 32'(ps_ready), 32'h0);
      for (int e = 1; e <= 16; e++) begin
         tick();
         chk("mid_ready", 32'(ps_ready), (e >= 16) ? 32'h1 : 32'h0);
      end
      lookup_all_weak("mid_lookup");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gshare_predictor_state.md
Name: gshare_predictor_state

Overview:
- Parametrised successor to the bimodal predictor-state RAM in the RISC-V branch prediction unit.
- Holds an array of CTR_WIDTH-bit saturating counters, PS_SIZE-bit indexed.
- Optionally hashes the fetch index with a global history register (gshare).
- Adds a post-reset initialisation sweep and a registered read with write-to-read bypass; sits between fetch and writeback/branch resolution.

Parameters:
- PS_SIZE, 8: log2(number of counter entries).
- CTR_WIDTH, 2: counter width in bits; legal range 2..4.
- GHR_SIZE, 8: global history length in bits; must satisfy 1 <= GHR_SIZE <= PS_SIZE.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- fch_addr_nxt  in  PS_SIZE  next fetch index (PC-derived).
- fch_predict  in  1  1 => look up a prediction; result valid next cycle.
- fch_pred_state  out  CTR_WIDTH  counter value read for the last lookup.
- fch_pred_taken  out  1  MSB of fch_pred_state.
- fch_ps_addr  out  PS_SIZE  hashed index used by the last lookup; returned at writeback as wrb_ps_addr.
- ps_ready  out  1  1 => init sweep done; lookups and updates accepted.
- wrb_update_bpu  in  1  1 => update counter and history this cycle.
- wrb_was_pred  in  1  1 => wrb_ps_state is valid.
- wrb_ps_state  in  CTR_WIDTH  counter value used at prediction time.
- wrb_ps_addr  in  PS_SIZE  index to write.
- wrb_direction  in  1  resolved outcome (1 = taken).

Behaviour:
- Constants: WEAK_NT = 2^(CTR_WIDTH-1)-1, WEAK_T = 2^(CTR_WIDTH-1), MAX = 2^CTR_WIDTH-1.
- Reset values (reset=0 at clk edge):
  - fch_pred_state = WEAK_NT; fch_pred_taken = 0; fch_ps_addr = 0; ps_ready = 0; ghr = 0.
  - FSM enters INIT with sweep_idx = 0.
- FSM state INIT:
  - Each cycle, writes WEAK_NT to entry sweep_idx, then increments sweep_idx.
  - After writing entry 2^PS_SIZE-1, moves to READY. ps_ready rises on the following edge, exactly 2^PS_SIZE cycles after reset is released.
  - fch_predict and wrb_update_bpu are ignored; ghr and outputs hold their reset values.
- FSM state READY:
  - Terminal state; only reset leaves it.
  - Reset asserted mid-sweep or in READY restarts INIT at index 0.
- Index hash: idx = fch_addr_nxt XOR zero-extend(ghr) to PS_SIZE, using the ghr value before any same-cycle update.
- Lookup: with fch_predict=1 in cycle N, on edge N+1:
  - fch_ps_addr <= idx; fch_pred_state <= ram[idx].
  - Outputs hold until the next lookup, even if that entry is rewritten.
  - Bypass: if wrb_update_bpu=1 and wrb_ps_addr==idx in the same cycle, fch_pred_state takes the new write data, not the stale RAM value.
- Update data when wrb_update_bpu=1:
  - wrb_was_pred=1: taken => min(wrb_ps_state+1, MAX); not-taken => max(wrb_ps_state-1, 0). Saturating, no wrap.
  - wrb_was_pred=0: taken => WEAK_T; not-taken => WEAK_NT.
- Write: ram[wrb_ps_addr] <= update data on the same edge. Write and read to different indices in one cycle are both honoured.
- History: on each accepted update, ghr <= {ghr[GHR_SIZE-2:0], wrb_direction}. For GHR_SIZE=1, ghr <= wrb_direction.
- RAM: 2^PS_SIZE x CTR_WIDTH, inferred as block RAM (one write port, one synchronous read port).

Optional Feature:
- Macro: PS_GSHARE_EN.
- Defined: gshare as above; ghr register present.
- Undefined: ghr removed; idx = fch_addr_nxt (pure bimodal). Update and history ports stay present; history has no effect.
- All other behaviour is identical in both builds.

Test Plan:
- Init: release reset, PS_SIZE=4. Expect ps_ready=0 for 16 cycles, then 1. Lookups at indices 0..15 each return 2'b01; fch_predict during INIT leaves fch_ps_addr=0.
- Saturation, CTR_WIDTH=2: update idx 5 with was_pred=1, state=11, dir=1 -> read 11. Then state=00, dir=0 -> read 00.
- Init on first encounter: was_pred=0, dir=1 at idx 3 -> lookup returns 10, fch_pred_taken=1. With CTR_WIDTH=3, same stimulus -> 100.
- Bypass: same cycle, fch_predict to idx 7 (ghr=0) and write 11 to idx 7 -> next cycle fch_pred_state=11.
- Gshare, PS_GSHARE_EN, GHR_SIZE=4: updates dir 1,0,1,1 -> ghr=1011. Lookup fch_addr_nxt=0x0F -> fch_ps_addr=0x04. Without the macro -> 0x0F.
- Reset mid-sweep: assert reset at sweep_idx 9, release -> ps_ready low for full 2^PS_SIZE cycles again; all entries read WEAK_NT.
